// File: rtl/instruction_fetch_stage_pkg.sv
// rtl/instruction_fetch_stage_pkg.sv - shared types and constants for the fetch stage
//
// Contents:
//   fetch_state_t   fetch FSM state encoding (IDLE, FETCH, FULL, DRAIN)
//   PS_*            program-counter select encoding driven by control
//   IFS_INSTR_WIDTH default instruction word width
//   IFS_WORD_BYTES  byte distance between sequential instructions

package instruction_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Control maps pc_advance onto PS_INC; without it the PC holds
    // unless a branch is being taken.
    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_LOAD   = 2'b10;
    localparam logic [1:0] PS_BRANCH = 2'b11;

    localparam int IFS_INSTR_WIDTH = 32;
    localparam int IFS_WORD_BYTES  = 4;

endpackage

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - instruction fetch stage with skid register and flush drain
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   PC, PC4             current PC and PC+4 from the program counter
//   pc_advance          commit strobe; the PC steps on the same edge
//   mem_req, mem_addr   instruction memory request, address held while pending
//   mem_ack, mem_data   request completion and returned instruction word
//   stall               decode cannot take IR this cycle
//   flush               taken branch; drop in-flight work and IR
//   IR, IR_PC, IR_PC4   instruction register with its address and address+4
//   IR_valid            IR holds a live instruction

module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = IFS_INSTR_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  PC,
    input  logic [ADDR_WIDTH-1:0]  PC4,
    output logic                   pc_advance,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    input  logic                   stall,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] IR,
    output logic [ADDR_WIDTH-1:0]  IR_PC,
    output logic [ADDR_WIDTH-1:0]  IR_PC4,
    output logic                   IR_valid
);

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(IFS_WORD_BYTES);

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic [INSTR_WIDTH-1:0] skid_data;
    logic [ADDR_WIDTH-1:0]  skid_pc;

    logic slot_free;
    logic req_raw;
    logic commit_mem;
    logic commit_skid;
    logic capture_skid;
    logic load_fetch_pc;

    assign slot_free = !IR_valid || !stall;

    always_comb begin
        state_next    = state;
        req_raw       = 1'b0;
        commit_mem    = 1'b0;
        commit_skid   = 1'b0;
        capture_skid  = 1'b0;
        load_fetch_pc = 1'b0;

        case (state)
            IDLE: begin
                // Always sample PC here so a flush landing in IDLE still
                // picks up the branch target on the following cycle.
                load_fetch_pc = 1'b1;
                state_next    = flush ? IDLE : FETCH;
            end
            FETCH: begin
                req_raw = 1'b1;
                if (flush) begin
                    // An unacknowledged request must run to completion.
                    state_next = mem_ack ? IDLE : DRAIN;
                end else if (mem_ack) begin
                    if (slot_free) begin
                        commit_mem = 1'b1;
                    end else begin
                        capture_skid = 1'b1;
                        state_next   = FULL;
                    end
                end
            end
            FULL: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (slot_free) begin
                    commit_skid = 1'b1;
                    state_next  = FETCH;
                end
            end
            DRAIN: begin
                req_raw = 1'b1;
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset is folded into the combinational outputs so nothing leaks out
    // while the state register is still being cleared.
    assign pc_advance = (commit_mem || commit_skid) && !reset;
    assign mem_req    = req_raw && !reset;
    assign mem_addr   = fetch_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= '0;
            skid_data  <= '0;
            skid_pc    <= '0;
            IR         <= '0;
            IR_PC      <= '0;
            IR_PC4     <= '0;
            IR_valid   <= 1'b0;
        end else begin
            state <= state_next;

            if (load_fetch_pc) begin
                fetch_addr <= PC;
            end else if (commit_mem || commit_skid) begin
                fetch_addr <= PC4;
            end

            if (capture_skid) begin
                skid_data <= mem_data;
                skid_pc   <= fetch_addr;
            end

            if (commit_mem) begin
                IR       <= mem_data;
                IR_PC    <= fetch_addr;
                IR_PC4   <= fetch_addr + WORD_STEP;
                IR_valid <= 1'b1;
            end else if (commit_skid) begin
                IR       <= skid_data;
                IR_PC    <= skid_pc;
                IR_PC4   <= skid_pc + WORD_STEP;
                IR_valid <= 1'b1;
            end else if (flush || (IR_valid && !stall)) begin
                IR_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - self-checking bench for instruction_fetch_stage

module tb_instruction_fetch_stage;
    import instruction_fetch_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] PC, PC4;
    logic        pc_advance, mem_req, mem_ack, stall, flush;
    logic [63:0] mem_addr, IR_PC, IR_PC4;
    logic [31:0] mem_data, IR;
    logic        IR_valid;

    instruction_fetch_stage #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .PC(PC), .PC4(PC4),
        .pc_advance(pc_advance), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .stall(stall), .flush(flush),
        .IR(IR), .IR_PC(IR_PC), .IR_PC4(IR_PC4), .IR_valid(IR_valid)
    );

    always #5 clock = ~clock;

    int n_pass = 0, n_total = 0;
    int cyc = 0, lat = 0, wait_cnt = 0, adv_cnt = 0;
    logic [63:0] rst_pc = 64'h100, pc_r = 64'h100, target = 64'h0;

    // Behavioural model: a transaction view of the stage.
    bit          m_gap = 1'b1;        // between transactions, next cycle starts one from PC
    bit          m_req = 1'b0;        // a memory request is open
    bit          m_drop = 1'b0;       // open request belongs to a flushed path
    logic [63:0] m_addr = '0;
    logic [95:0] held_q[$];           // acked words waiting for decode room
    logic [31:0] e_ir = '0;
    logic [63:0] e_ir_pc = '0, e_ir_pc4 = '0;
    bit          e_v = 1'b0;

    function automatic logic [31:0] word_at(logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF ^ {a[63:48], 16'h0000};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic cycle();
        bit          exp_adv, free, req_seen;
        logic [31:0] w;
        logic [63:0] wpc;
        // memory responds to the DUT's request after lat waiting cycles
        mem_ack  = 1'b0;
        mem_data = 32'hBAD0_0000 | 32'(cyc[15:0]);
        if (mem_req === 1'b1 && wait_cnt >= lat) begin
            mem_ack  = 1'b1;
            mem_data = word_at(mem_addr);
        end
        #1;
        free    = !e_v || !stall;
        exp_adv = !reset && !flush && free &&
                  ((m_req && !m_drop && mem_ack) || held_q.size() > 0);
        if (!reset) begin
            check("mem_req", mem_req, m_req);
            if (m_req) check("mem_addr", mem_addr, m_addr);
        end
        check("pc_advance", pc_advance, exp_adv);
        if (pc_advance === 1'b1) adv_cnt++;
        req_seen = (mem_req === 1'b1);
        @(posedge clock);
        // model update with this cycle's inputs
        if (reset) begin
            m_gap = 1; m_req = 0; m_drop = 0; held_q.delete();
            e_ir = '0; e_ir_pc = '0; e_ir_pc4 = '0; e_v = 0;
        end else if (flush) begin
            e_v = 0;
            held_q.delete();
            if (m_req && !mem_ack) m_drop = 1;
            else begin m_req = 0; m_gap = 1; m_drop = 0; end
        end else if (exp_adv) begin
            if (held_q.size() > 0) begin w = held_q[0][95:64]; wpc = held_q[0][63:0]; end
            else begin w = mem_data; wpc = m_addr; end
            held_q.delete();
            e_ir = w; e_ir_pc = wpc; e_ir_pc4 = wpc + 64'd4; e_v = 1;
            m_req = 1; m_drop = 0; m_addr = PC4;
        end else begin
            if (e_v && !stall) e_v = 0;
            if (m_req && mem_ack) begin
                if (!m_drop) held_q.push_back({mem_data, m_addr});
                m_gap = m_drop; m_req = 0; m_drop = 0;
            end else if (m_gap) begin
                m_gap = 0; m_req = 1; m_drop = 0; m_addr = PC;
            end
        end
        #1;
        check("IR_valid", IR_valid, e_v);
        check("IR", IR, e_ir);
        check("IR_PC", IR_PC, e_ir_pc);
        check("IR_PC4", IR_PC4, e_ir_pc4);
        // program counter and memory wait bookkeeping
        if (reset) begin
            pc_r = rst_pc; wait_cnt = 0;
        end else begin
            if (flush) pc_r = target;            // PS_BRANCH
            else if (exp_adv) pc_r = pc_r + 64'd4; // PS_INC
            if (req_seen) wait_cnt = mem_ack ? 0 : wait_cnt + 1;
        end
        PC = pc_r; PC4 = pc_r + 64'd4;
        cyc++;
        @(negedge clock);
    endtask

    logic [15:0] stall_pat = 16'b0011_0100_1110_0010;
    logic [15:0] lat_pat   = 16'b0100_1001_0010_0110;

    initial begin
        reset = 1; stall = 0; flush = 0; mem_ack = 0; mem_data = '0;
        PC = rst_pc; PC4 = rst_pc + 64'd4;
        @(negedge clock);
        repeat (2) cycle();
        reset = 0;

        // zero-wait streaming
        cycle();
        check("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 64'h100);
        adv_cnt = 0;
        cycle(); check("seq0_pc", IR_PC, 64'h100); check("seq0_ir", IR, 32'h1357_9ADF);
        cycle(); check("seq1_pc", IR_PC, 64'h104);
        cycle(); check("seq2_pc", IR_PC, 64'h108); check("seq2_pc4", IR_PC4, 64'h10C);
        check("seq_adv", adv_cnt, 3);

        // three wait states
        lat = 3; adv_cnt = 0;
        repeat (4) cycle();
        check("slow_adv", adv_cnt, 1);
        check("slow_pc", IR_PC, 64'h10C);
        check("slow_valid", IR_valid, 1'b1);

        // stall with ack arriving -> skid
        lat = 0; stall = 1;
        cycle();
        check("full_req", mem_req, 1'b0);
        check("full_hold_pc", IR_PC, 64'h10C);
        cycle();
        check("full_hold_ir", IR, word_at(64'h10C));
        stall = 0; adv_cnt = 0;
        cycle();
        check("skid_pc", IR_PC, 64'h110);
        check("skid_adv", adv_cnt, 1);
        check("resume_addr", mem_addr, 64'h114);

        // flush while waiting for ack -> drain
        lat = 3;
        cycle();
        flush = 1; target = 64'h2000;
        cycle();
        flush = 0;
        check("drain_req", mem_req, 1'b1);
        check("drain_addr", mem_addr, 64'h114);
        repeat (2) cycle();
        check("drain_valid", IR_valid, 1'b0);
        lat = 0;
        cycle();
        check("branch_addr", mem_addr, 64'h2000);
        cycle();
        check("branch_pc", IR_PC, 64'h2000);

        // flush together with ack
        flush = 1; target = 64'h3000; adv_cnt = 0;
        cycle();
        flush = 0;
        check("flush_ack_adv", adv_cnt, 0);
        check("flush_ack_valid", IR_valid, 1'b0);
        cycle();
        check("flush_ack_addr", mem_addr, 64'h3000);
        cycle();

        // address wrap
        flush = 1; target = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        flush = 0;
        repeat (2) cycle();
        check("wrap_pc", IR_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pc4", IR_PC4, 64'h0);
        check("wrap_addr", mem_addr, 64'h0);

        // mixed stall / latency vectors
        for (int i = 0; i < 16; i++) begin
            stall = stall_pat[i];
            lat   = lat_pat[i] ? 1 : 0;
            cycle();
        end
        stall = 0;

        // reset in the middle of a pending fetch
        lat = 5;
        repeat (2) cycle();
        reset = 1;
        cycle();
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 64'h0);
        check("rst_ir", IR, 32'h0);
        check("rst_ir_pc", IR_PC, 64'h0);
        check("rst_ir_pc4", IR_PC4, 64'h0);
        check("rst_valid", IR_valid, 1'b0);
        check("rst_adv", pc_advance, 1'b0);
        reset = 0; lat = 0;
        repeat (5) cycle();
        check("post_rst_pc", IR_PC, 64'h10C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage directly downstream of the program counter; consumes PC/PC4 and drives the instruction memory request.
- Captures the returned word into the instruction register (IR) with its PC/PC4 and presents it to decode under valid/stall flow control.
- Emits a one-cycle pc_advance strobe; control maps it to the PC's increment select (PS=01); otherwise PS=00 (hold) unless branching.
- Handles variable-latency memory, decode stalls and branch flushes.

Parameters:
ADDR_WIDTH, 64, PC / memory address width
INSTR_WIDTH, 32, instruction word width

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
PC  input  ADDR_WIDTH  current PC from program counter
PC4  input  ADDR_WIDTH  PC+4 from program counter
pc_advance  output  1  combinational; high in the commit cycle, PC steps at the same edge
mem_req  output  1  instruction memory request
mem_addr  output  ADDR_WIDTH  request address, stable while mem_req high
mem_ack  input  1  data valid this cycle, completes request
mem_data  input  INSTR_WIDTH  instruction word
stall  input  1  decode cannot accept IR this cycle
flush  input  1  branch taken; discard in-flight and IR contents
IR  output  INSTR_WIDTH  instruction register
IR_PC  output  ADDR_WIDTH  address of IR
IR_PC4  output  ADDR_WIDTH  IR_PC+4
IR_valid  output  1  IR holds a live instruction

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high, sampled on the rising edge of clock.
  - Reset overrides everything and aborts any outstanding request without waiting for mem_ack.
  - Reset values: state=IDLE, mem_req=0, mem_addr=0, IR=0, IR_PC=0, IR_PC4=0, IR_valid=0, skid=0, pc_advance=0.
- Definitions:
  - slot_free = !IR_valid || !stall.
  - Decode consumes IR on any edge where IR_valid && !stall.
  - "Commit" loads IR, IR_PC, IR_PC4 and sets IR_valid=1.
  - If IR_valid && !stall at an edge with no commit, IR_valid<=0.
- States:
  - IDLE: mem_req=0. fetch_addr<=PC; next state FETCH.
  - FETCH: mem_req=1, mem_addr=fetch_addr.
    - mem_ack && slot_free: commit mem_data with IR_PC=fetch_addr, IR_PC4=fetch_addr+4. pc_advance=1. fetch_addr<=PC4. Stay in FETCH (back-to-back).
    - mem_ack && !slot_free: skid<=mem_data (with its PC); next state FULL.
    - !mem_ack: hold all outputs.
  - FULL: mem_req=0.
    - When slot_free: commit skid, pc_advance=1, fetch_addr<=PC4, next state FETCH.
  - DRAIN: mem_req=1, mem_addr=fetch_addr.
    - On mem_ack: discard data, no pc_advance, next state IDLE.
- Flush (priority over commit):
  - Any state: IR_valid<=0, pc_advance=0, skid discarded.
  - FETCH without mem_ack in the same cycle: next state DRAIN, because a request is never dropped mid-transaction.
  - FETCH with mem_ack, FULL or IDLE: next state IDLE.
  - DRAIN: stay in DRAIN.
  - IDLE then reloads from the (new) branch-target PC.
- Timing:
  - Latency: reset release to first mem_req is 1 cycle (IDLE).
  - Ack in cycle N gives IR_valid at N+1.
  - Zero-wait memory sustains 1 instruction/cycle.
- Arithmetic and alignment:
  - IR_PC4 = fetch_addr+4, modulo 2^ADDR_WIDTH; FFFF_FFFF_FFFF_FFFC wraps to 0.
  - No alignment check; mem_addr[1:0] is passed through unchanged.

Decomposition:
- Shared Verilog header for the CPU holds:
  - FSM state localparams: IDLE=2'd0, FETCH=2'd1, FULL=2'd2, DRAIN=2'd3.
  - PS encoding constants: 00 hold, 01 +4, 10 load, 11 branch.
  - INSTR_WIDTH.
- No sub-module needed; skid register and FSM stay inline.

Test Plan:
- Reset high 2 cycles, PC=0x100, zero-wait memory, stall=0 -> mem_req at cycle 1 with addr 0x100; IR_PC 0x100, 0x104, 0x108 on consecutive cycles; pc_advance high every cycle.
- mem_ack delayed 3 cycles -> mem_req/mem_addr stable for 4 cycles; IR_valid rises exactly one cycle after ack; a single pc_advance pulse.
- stall high with IR_valid=1 and ack arriving -> FULL, mem_req=0, IR unchanged; stall low -> skid word committed, pc_advance pulses once, fetch resumes at PC4.
- flush while waiting for ack -> DRAIN keeps mem_req/addr until ack, data discarded, IR_valid=0; new PC=0x2000 fetched next.
- flush and mem_ack in the same cycle -> no commit, no pc_advance, IDLE then fetch from branch-target PC.
- PC=0xFFFF_FFFF_FFFF_FFFC -> IR_PC4=0. Reset asserted during FETCH -> all outputs zero the next cycle.
